// File: rtl/vec_pkg.sv
// Shared definitions for the vector element sequencer and instruction decoder.
// Contents: sizing constants, ALU opcode encodings, sequencer FSM states.
// Optional feature macro used by dependants: VSEQ_MASK_EN (per-element write mask).
package vec_pkg;

    localparam int unsigned VLEN   = 8;                 // max elements per vector
    localparam int unsigned ELEM_W = 8;                 // element width, matches ALU
    localparam int unsigned IDX_W  = $clog2(VLEN);      // element index width
    localparam int unsigned LEN_W  = $clog2(VLEN + 1);  // holds 0..VLEN

    typedef logic [3:0] opcode_t;

    // Vector-vector
    localparam opcode_t OP_VADD  = 4'b0001;
    localparam opcode_t OP_VSUB  = 4'b0010;
    // Vector-scalar
    localparam opcode_t OP_XOR_S = 4'b0101;
    localparam opcode_t OP_SHL_S = 4'b0110;
    localparam opcode_t OP_SHR_S = 4'b0111;
    localparam opcode_t OP_ROL_S = 4'b1000;
    localparam opcode_t OP_ROR_S = 4'b1001;
    localparam opcode_t OP_ADD_S = 4'b1010;
    localparam opcode_t OP_SUB_S = 4'b1011;
    localparam opcode_t OP_VFS   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } seq_state_e;

endpackage

// File: rtl/vec_elem_seq_if.sv
// Bundle of the sequencer's instruction, register-file, ALU and writeback signals.
// Modports:
//   slave  - the sequencer (vec_elem_seq)
//   master - the surrounding datapath / instruction issue side
// Optional feature macro: VSEQ_MASK_EN adds the per-element write mask.
interface vec_elem_seq_if;
    import vec_pkg::*;

    // Instruction issue
    logic              start;
    opcode_t           opcode;
    logic [LEN_W-1:0]  vlen;
    logic [ELEM_W-1:0] scalar;
`ifdef VSEQ_MASK_EN
    logic [VLEN-1:0]   mask;
`endif
    logic              busy;
    logic              done;
    logic              illegal;
    // Register-file read
    logic [IDX_W-1:0]  rd_idx;
    logic [ELEM_W-1:0] rd_data_a;
    logic [ELEM_W-1:0] rd_data_b;
    // ALU
    logic [ELEM_W-1:0] alu_a;
    logic [ELEM_W-1:0] alu_b;
    opcode_t           alu_op;
    logic [ELEM_W-1:0] alu_res;
    // Writeback
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ELEM_W-1:0] wr_data;

    modport slave (
`ifdef VSEQ_MASK_EN
        input  mask,
`endif
        input  start, opcode, vlen, scalar, rd_data_a, rd_data_b, alu_res,
        output busy, done, illegal, rd_idx, alu_a, alu_b, alu_op, wr_en, wr_idx, wr_data
    );

    modport master (
`ifdef VSEQ_MASK_EN
        output mask,
`endif
        output start, opcode, vlen, scalar, rd_data_a, rd_data_b, alu_res,
        input  busy, done, illegal, rd_idx, alu_a, alu_b, alu_op, wr_en, wr_idx, wr_data
    );

endinterface

// File: rtl/vop_decode.sv
// Combinational vector opcode classifier, shared with the instruction decoder.
// Ports:
//   opcode_i     - 4-bit ALU opcode
//   legal_o      - opcode is defined
//   use_scalar_o - operand B comes from the scalar rather than the register file
module vop_decode
    import vec_pkg::*;
(
    input  opcode_t opcode_i,
    output logic    legal_o,
    output logic    use_scalar_o
);

    always_comb begin
        legal_o      = 1'b0;
        use_scalar_o = 1'b0;
        unique case (opcode_i)
            OP_VADD, OP_VSUB: begin
                legal_o = 1'b1;
            end
            OP_XOR_S, OP_SHL_S, OP_SHR_S, OP_ROL_S, OP_ROR_S,
            OP_ADD_S, OP_SUB_S, OP_VFS: begin
                legal_o      = 1'b1;
                use_scalar_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_elem_seq.sv
// Vector element sequencer: accepts one instruction and walks elements 0..vlen-1,
// one per cycle, feeding the element ALU and issuing registered writebacks.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous reset, active-high
//   bus - vec_elem_seq_if.slave: start/opcode/vlen/scalar in, busy/done/illegal out,
//         rd_idx out / rd_data_a,rd_data_b in, alu_a/alu_b/alu_op out / alu_res in,
//         wr_en/wr_idx/wr_data out
// Optional feature macro: VSEQ_MASK_EN - mask captured on accept; elements whose mask
// bit is 0 are still sequenced but produce no wr_en.
module vec_elem_seq
    import vec_pkg::*;
(
    input logic           clk,
    input logic           rst,
    vec_elem_seq_if.slave bus
);

    seq_state_e        state_q, state_d;
    opcode_t           op_q;
    logic [LEN_W-1:0]  vlen_q;
    logic [ELEM_W-1:0] scalar_q;
    logic              use_scalar_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              wr_en_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [ELEM_W-1:0] wr_data_q;
    logic              done_q;
    logic              illegal_q;
`ifdef VSEQ_MASK_EN
    logic [VLEN-1:0]   mask_q;
`endif

    logic             legal;
    logic             use_scalar;
    logic [LEN_W-1:0] vlen_clamp;
    logic             run;
    logic             accept;
    logic             last;

    vop_decode u_decode (
        .opcode_i     (bus.opcode),
        .legal_o      (legal),
        .use_scalar_o (use_scalar)
    );

    assign vlen_clamp = (bus.vlen > LEN_W'(VLEN)) ? LEN_W'(VLEN) : bus.vlen;
    assign run        = (state_q == StRun);
    // DRAIN only flushes the registered last write, so a new instruction may be taken there.
    assign accept     = bus.start && !run;
    assign last       = run && (LEN_W'(cnt_q) == vlen_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDrain: begin
                state_d = StIdle;
                if (accept && legal && (vlen_clamp != '0)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last) begin
                    state_d = StDrain;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            vlen_q       <= '0;
            scalar_q     <= '0;
            use_scalar_q <= 1'b0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_idx_q     <= '0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef VSEQ_MASK_EN
            mask_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;

            if (accept) begin
                if (!legal) begin
                    illegal_q <= 1'b1;
                    done_q    <= 1'b1;
                end else if (vlen_clamp == '0) begin
                    done_q <= 1'b1;
                end else begin
                    op_q         <= bus.opcode;
                    vlen_q       <= vlen_clamp;
                    scalar_q     <= bus.scalar;
                    use_scalar_q <= use_scalar;
                    cnt_q        <= '0;
`ifdef VSEQ_MASK_EN
                    mask_q       <= bus.mask;
`endif
                end
            end

            if (run) begin
`ifdef VSEQ_MASK_EN
                wr_en_q <= mask_q[cnt_q];
`else
                wr_en_q <= 1'b1;
`endif
                wr_idx_q  <= cnt_q;
                wr_data_q <= bus.alu_res;
                // Hold cnt on the last element so it never wraps at vlen=VLEN.
                if (last) begin
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Outside RUN the ALU inputs are parked at zero.
    assign bus.rd_idx  = run ? cnt_q : '0;
    assign bus.alu_a   = run ? bus.rd_data_a : '0;
    assign bus.alu_b   = !run ? '0 : (use_scalar_q ? scalar_q : bus.rd_data_b);
    assign bus.alu_op  = run ? op_q : '0;

    assign bus.busy    = run;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_idx  = wr_idx_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_vec_elem_seq.sv
// Directed testbench for vec_elem_seq with a register-file and element-ALU model.
// Define VSEQ_MASK_EN to also exercise the write mask.
module tb_vec_elem_seq;
    import vec_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [7:0] ra [8];
    logic [7:0] rb [8];

    vec_elem_seq_if bus ();

    vec_elem_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rd_data_a = ra[bus.rd_idx];
    assign bus.rd_data_b = rb[bus.rd_idx];

    always_comb begin
        case (bus.alu_op)
            4'b0001, 4'b1010: bus.alu_res = bus.alu_a + bus.alu_b;
            4'b0010, 4'b1011: bus.alu_res = bus.alu_a - bus.alu_b;
            4'b0101:          bus.alu_res = bus.alu_a ^ bus.alu_b;
            default:          bus.alu_res = bus.alu_a;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds start for one edge (T0); returns in cycle T0+1.
    task automatic issue(input logic [3:0] op, input logic [3:0] vl, input logic [7:0] sc);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.vlen   = vl;
        bus.scalar = sc;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.illegal, bus.wr_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000",
                     {bus.busy, bus.done, bus.illegal, bus.wr_en});
        end
        checks++;
        if (bus.wr_idx !== 3'd0 || bus.wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_wb got idx=%0d data=%0d want 0/0", bus.wr_idx, bus.wr_data);
        end
        checks++;
        if (bus.rd_idx !== 3'd0 || bus.alu_op !== 4'd0 || bus.alu_a !== 8'd0 ||
            bus.alu_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_alu got rd=%0d op=%0d a=%0d b=%0d want all 0",
                     bus.rd_idx, bus.alu_op, bus.alu_a, bus.alu_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vv_add();
        logic [7:0] exp [4];
        exp = '{8'd11, 8'd22, 8'd33, 8'd44};
        ra = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        rb = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
        issue(4'b0001, 4'd4, 8'd0);
        checks++;
        if (bus.busy !== 1'b1 || bus.rd_idx !== 3'd0 || bus.alu_a !== 8'd1 ||
            bus.alu_b !== 8'd10 || bus.alu_op !== 4'b0001 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL vv_first busy=%b rd=%0d a=%0d b=%0d op=%0d we=%b want 1/0/1/10/1/0",
                     bus.busy, bus.rd_idx, bus.alu_a, bus.alu_b, bus.alu_op, bus.wr_en);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_idx !== 3'(k) || bus.wr_data !== exp[k]) begin
                errors++;
                $display("FAIL vv_wb k=%0d got we=%b idx=%0d data=%0d want 1/%0d/%0d",
                         k, bus.wr_en, bus.wr_idx, bus.wr_data, k, exp[k]);
            end
            checks++;
            if (bus.done !== (k == 3)) begin
                errors++;
                $display("FAIL vv_done k=%0d got=%b want=%b", k, bus.done, (k == 3));
            end
        end
        tick();
        checks++;
        if ({bus.wr_en, bus.done, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL vv_after got we/done/busy=%b want 000",
                     {bus.wr_en, bus.done, bus.busy});
        end
    endtask

    task automatic test_vs_add();
        int nbusy;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            ra[i] = 8'(i);
            rb[i] = 8'hAA;
        end
        issue(4'b1010, 4'd8, 8'd5);
        for (int c = 1; c <= 10; c++) begin
            logic we;
            we = (c >= 2 && c <= 9);
            if (bus.busy === 1'b1) nbusy++;
            checks++;
            if (bus.alu_b !== ((c <= 8) ? 8'd5 : 8'd0)) begin
                errors++;
                $display("FAIL vs_alu_b c=%0d got=%0d want=%0d", c, bus.alu_b,
                         (c <= 8) ? 5 : 0);
            end
            checks++;
            if (bus.wr_en !== we || (we && bus.wr_data !== 8'(c + 3))) begin
                errors++;
                $display("FAIL vs_wb c=%0d got we=%b data=%0d want %b/%0d",
                         c, bus.wr_en, bus.wr_data, we, c + 3);
            end
            checks++;
            if (bus.done !== (c == 9)) begin
                errors++;
                $display("FAIL vs_done c=%0d got=%b want=%b", c, bus.done, (c == 9));
            end
            tick();
        end
        checks++;
        if (nbusy != 8) begin
            errors++;
            $display("FAIL vs_busy_cycles got=%0d want=8", nbusy);
        end
    endtask

    task automatic test_illegal();
        issue(4'b0011, 4'd4, 8'd0);
        checks++;
        if ({bus.illegal, bus.done, bus.busy, bus.wr_en} !== 4'b1100) begin
            errors++;
            $display("FAIL ill_pulse got ill/done/busy/we=%b want 1100",
                     {bus.illegal, bus.done, bus.busy, bus.wr_en});
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++;
            if ({bus.illegal, bus.done, bus.busy, bus.wr_en} !== 4'b0000) begin
                errors++;
                $display("FAIL ill_quiet c=%0d got ill/done/busy/we=%b want 0000",
                         c, {bus.illegal, bus.done, bus.busy, bus.wr_en});
            end
        end
    endtask

    task automatic test_vlen0_clamp();
        int nw;
        issue(4'b0001, 4'd0, 8'd0);
        checks++;
        if ({bus.done, bus.illegal, bus.busy, bus.wr_en} !== 4'b1000) begin
            errors++;
            $display("FAIL vlen0 got done/ill/busy/we=%b want 1000",
                     {bus.done, bus.illegal, bus.busy, bus.wr_en});
        end
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL vlen0_after got done/busy/we=%b want 000",
                     {bus.done, bus.busy, bus.wr_en});
        end
        for (int i = 0; i < 8; i++) begin
            ra[i] = 8'(3 * i);
            rb[i] = 8'd100;
        end
        nw = 0;
        issue(4'b0001, 4'd12, 8'd0);
        for (int c = 1; c <= 11; c++) begin
            if (bus.wr_en === 1'b1) begin
                checks++;
                if (bus.wr_idx !== 3'(nw) || bus.wr_data !== 8'(100 + 3 * nw)) begin
                    errors++;
                    $display("FAIL clamp_wb n=%0d got idx=%0d data=%0d want %0d/%0d",
                             nw, bus.wr_idx, bus.wr_data, nw, 100 + 3 * nw);
                end
                nw++;
            end
            checks++;
            if (bus.done !== (c == 9)) begin
                errors++;
                $display("FAIL clamp_done c=%0d got=%b want=%b", c, bus.done, (c == 9));
            end
            tick();
        end
        checks++;
        if (nw != 8) begin
            errors++;
            $display("FAIL clamp_count got=%0d want=8", nw);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp [4];
        int nw;
        exp = '{8'd45, 8'd34, 8'd23, 8'd12};
        ra = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0};
        rb = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        nw = 0;
        issue(4'b0010, 4'd4, 8'd0);
        for (int c = 1; c <= 8; c++) begin
            logic we;
            we = (c >= 2 && c <= 5);
            if (bus.wr_en === 1'b1) nw++;
            checks++;
            if (bus.wr_en !== we || (we && (bus.wr_idx !== 3'(c - 2) ||
                                            bus.wr_data !== exp[c - 2]))) begin
                errors++;
                $display("FAIL busy_ign_wb c=%0d got we=%b idx=%0d data=%0d want %b",
                         c, bus.wr_en, bus.wr_idx, bus.wr_data, we);
            end
            checks++;
            if (bus.done !== (c == 5) || bus.busy !== (c <= 4)) begin
                errors++;
                $display("FAIL busy_ign_ctl c=%0d got done=%b busy=%b want %b/%b",
                         c, bus.done, bus.busy, (c == 5), (c <= 4));
            end
            if (c == 2) begin
                bus.start  = 1'b1;
                bus.opcode = 4'b0001;
                bus.vlen   = 4'd2;
            end
            tick();
            bus.start = 1'b0;
        end
        checks++;
        if (nw != 4) begin
            errors++;
            $display("FAIL busy_ign_count got=%0d want=4", nw);
        end
    endtask

    task automatic test_reset_abort();
        ra = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        rb = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        issue(4'b0001, 4'd4, 8'd0);
        tick();
        tick();
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_idx !== 3'd1 || bus.wr_data !== 8'd3) begin
            errors++;
            $display("FAIL abort_pre got we=%b idx=%0d data=%0d want 1/1/3",
                     bus.wr_en, bus.wr_idx, bus.wr_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.wr_en, bus.busy, bus.done} !== 3'b000 || bus.wr_idx !== 3'd0 ||
            bus.wr_data !== 8'd0 || bus.alu_op !== 4'd0) begin
            errors++;
            $display("FAIL abort_rst got we/busy/done=%b idx=%0d data=%0d op=%0d want 0",
                     {bus.wr_en, bus.busy, bus.done}, bus.wr_idx, bus.wr_data, bus.alu_op);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({bus.wr_en, bus.busy, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet c=%0d got we/busy/done=%b want 000",
                         c, {bus.wr_en, bus.busy, bus.done});
            end
        end
    endtask

`ifdef VSEQ_MASK_EN
    task automatic test_mask();
        logic [7:0] exp [4];
        logic [3:0] m;
        exp = '{8'd11, 8'd22, 8'd33, 8'd44};
        m = 4'b0101;
        ra = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        rb = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
        bus.mask = 8'b0000_0101;
        issue(4'b0001, 4'd4, 8'd0);
        bus.mask = '1;
        for (int c = 1; c <= 6; c++) begin
            logic we;
            we = (c >= 2 && c <= 5) ? m[c - 2] : 1'b0;
            checks++;
            if (bus.wr_en !== we || (we && (bus.wr_idx !== 3'(c - 2) ||
                                            bus.wr_data !== exp[c - 2]))) begin
                errors++;
                $display("FAIL mask_wb c=%0d got we=%b idx=%0d data=%0d want %b",
                         c, bus.wr_en, bus.wr_idx, bus.wr_data, we);
            end
            checks++;
            if (bus.done !== (c == 5)) begin
                errors++;
                $display("FAIL mask_done c=%0d got=%b want=%b", c, bus.done, (c == 5));
            end
            tick();
        end
    endtask
`endif

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = 4'd0;
        bus.vlen   = 4'd0;
        bus.scalar = 8'd0;
`ifdef VSEQ_MASK_EN
        bus.mask   = '1;
`endif
        for (int i = 0; i < 8; i++) begin
            ra[i] = 8'd0;
            rb[i] = 8'd0;
        end

        test_reset();
        test_vv_add();
        test_vs_add();
        test_illegal();
        test_vlen0_clamp();
        test_busy_ignore();
        test_reset_abort();
`ifdef VSEQ_MASK_EN
        test_mask();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
